// File: rtl/cache_line_mem_resp.sv
// rtl/cache_line_mem_resp.sv - memory-side line fill / writeback responder for cache_ctrl
module cache_line_mem_resp #(
    parameter int WORDS = 16,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [AW-1:0]       req_addr,
    input  logic [WORDS*DW-1:0] wr_line,
    output logic                ready,
    output logic                tx_done,
    output logic [WORDS*DW-1:0] rd_line,
    output logic                mem_req,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wr_data,
    input  logic                mem_ack,
    input  logic [DW-1:0]       mem_rd_data
);

    localparam int CW   = $clog2(WORDS);
    localparam int BW   = $clog2(DW/8);
    localparam int OFFW = CW + BW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cnt_inc;
    logic                  we_q, we_d;
    logic [AW-OFFW-1:0]    base_q, base_d;
    logic [WORDS*DW-1:0]   wline_q, wline_d;
    logic [WORDS*DW-1:0]   rline_q, rline_d;
    logic                  mem_req_q, mem_req_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [DW-1:0]         mem_wr_data_q, mem_wr_data_d;
    logic                  tx_done_q, tx_done_d;

    // Byte-offset bits inside the line are discarded: the line base is always aligned.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^req_addr[OFFW-1:0];

    assign cnt_inc = cnt_q + CW'(1);

    // State and registered memory-port outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            base_q        <= '0;
            wline_q       <= '0;
            rline_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            tx_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            base_q        <= base_d;
            wline_q       <= wline_d;
            rline_q       <= rline_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            tx_done_q     <= tx_done_d;
        end
    end

    // Next-state: accept in IDLE (write wins), step one word per ack in XFER, pulse in DONE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        base_d        = base_q;
        wline_d       = wline_q;
        rline_d       = rline_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        tx_done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    state_d       = S_XFER;
                    cnt_d         = '0;
                    we_d          = wr_req;
                    base_d        = req_addr[AW-1:OFFW];
                    mem_req_d     = 1'b1;
                    mem_addr_d    = {req_addr[AW-1:OFFW], {OFFW{1'b0}}};
                    if (wr_req) begin
                        wline_d       = wr_line;
                        mem_wr_data_d = wr_line[DW-1:0];
                    end else begin
                        mem_wr_data_d = '0;
                    end
                end
            end
            S_XFER: begin
                if (mem_req_q && mem_ack) begin
                    if (!we_q) begin
                        rline_d[cnt_q*DW +: DW] = mem_rd_data;
                    end
                    if (cnt_q == CW'(WORDS-1)) begin
                        state_d   = S_DONE;
                        cnt_d     = '0;
                        mem_req_d = 1'b0;
                        we_d      = 1'b0;
                        tx_done_d = 1'b1;
                    end else begin
                        cnt_d         = cnt_inc;
                        mem_addr_d    = {base_q, cnt_inc, {BW{1'b0}}};
                        mem_wr_data_d = wline_q[cnt_inc*DW +: DW];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready       = (state_q == S_IDLE) && !rst;
    assign tx_done     = tx_done_q;
    assign rd_line     = rline_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule
